// File: rtl/axi_request_gen_p.sv
// Windowed request-word generator: issues numbered IDs on AXI-Stream, throttled by row completions.
// Configured and observed through an embedded AXI4-Lite register slave.
module axi_request_gen_p #(
  parameter int          DATA_W  = 256,
  parameter int          CNT_W   = 64,
  parameter int          WIN_MAX = 8,
  parameter logic [31:0] ID_INIT = 32'h0000_C008
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              row_complete_in,
  input  logic              button,
  output logic              idle_out,
  output logic [DATA_W-1:0] AXIS_TX_TDATA,
  output logic              AXIS_TX_TVALID,
  output logic              AXIS_TX_TLAST,
  input  logic              AXIS_TX_TREADY,
  input  logic [31:0]       S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  input  logic [2:0]        S_AXI_AWPROT,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [31:0]       S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  input  logic [2:0]        S_AXI_ARPROT,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY
);

  localparam logic [4:0] IDX_COUNTH   = 5'd0;
  localparam logic [4:0] IDX_COUNTL   = 5'd1;
  localparam logic [4:0] IDX_START    = 5'd2;
  localparam logic [4:0] IDX_ABORT    = 5'd3;
  localparam logic [4:0] IDX_WINDOW   = 5'd4;
  localparam logic [4:0] IDX_FIRST_ID = 5'd5;
  localparam logic [4:0] IDX_STATUS   = 5'd6;
  localparam logic [4:0] IDX_SENT_L   = 5'd7;
  localparam logic [4:0] IDX_DONE_L   = 5'd8;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  // state   | meaning
  // S_IDLE  | waiting for START write or button
  // S_RUN   | issuing requests while outstanding < window
  // S_DRAIN | no new requests, waiting for done to reach target
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t state_q, state_d;

  logic [31:0]      counth_q, countl_q, first_id_q;
  logic [7:0]       window_q, win_clamp;
  logic [CNT_W-1:0] target_q, target_d, sent_q, sent_d, done_q, done_d, outstanding;
  logic [31:0]      id_q, id_d;
  logic [7:0]       run_win_q, run_win_d;
  logic             cont_q, cont_d, aborted_q, aborted_d;
  logic             bvalid_q, rvalid_q;
  logic [1:0]       bresp_q;
  logic [31:0]      rdata_q, rd_mux;
  logic [4:0]       wr_idx, rd_idx;
  logic [63:0]      count_full, sent_ext, done_ext;
  logic             wr_en, rd_en, start_evt, abort_evt, tvalid, hs, last_beat, comp;
  logic             unused_ok;

  assign wr_idx     = S_AXI_AWADDR[6:2];
  assign rd_idx     = S_AXI_ARADDR[6:2];
  assign wr_en      = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
  assign rd_en      = S_AXI_ARVALID && !rvalid_q;
  assign start_evt  = (wr_en && wr_idx == IDX_START) || button;
  assign abort_evt  = wr_en && wr_idx == IDX_ABORT;
  assign count_full = {counth_q, countl_q};
  assign sent_ext   = 64'(sent_q);
  assign done_ext   = 64'(done_q);
  assign unused_ok  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB, S_AXI_AWADDR[31:7],
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[31:7], S_AXI_ARADDR[1:0],
                        count_full, sent_ext[63:32], done_ext[63:32]};

  // Full-width difference so the window compare stays correct past 2^32 requests.
  assign outstanding = sent_q - done_q;
  assign tvalid      = (state_q == S_RUN) && (outstanding < CNT_W'(run_win_q));
  assign hs          = tvalid && AXIS_TX_TREADY;
  assign last_beat   = !cont_q && ((sent_q + CNT_W'(1)) == target_q);
  assign comp        = row_complete_in && (state_q != S_IDLE) && (done_q < sent_q);

  assign AXIS_TX_TVALID = tvalid;
  assign AXIS_TX_TLAST  = tvalid && last_beat;
  assign idle_out       = (state_q == S_IDLE);

  always_comb begin
    AXIS_TX_TDATA = '0;
    if (tvalid) AXIS_TX_TDATA[31:0] = id_q;
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    sent_d    = sent_q;
    done_d    = done_q;
    id_d      = id_q;
    run_win_d = run_win_q;
    cont_d    = cont_q;
    aborted_d = aborted_q;
    if (hs) begin
      id_d   = id_q + 32'd1;
      sent_d = sent_q + CNT_W'(1);
    end
    if (comp) done_d = done_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        done_d = done_q;
        if (start_evt) begin
          state_d   = S_RUN;
          target_d  = count_full[CNT_W-1:0];
          cont_d    = (count_full[CNT_W-1:0] == '0);
          id_d      = first_id_q;
          run_win_d = window_q;
          sent_d    = '0;
          done_d    = '0;
          aborted_d = 1'b0;
        end
      end
      S_RUN: begin
        if (abort_evt) begin
          state_d   = S_DRAIN;
          target_d  = sent_d;
          aborted_d = 1'b1;
        end else if (hs && last_beat) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort_evt || done_d == target_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      sent_q    <= '0;
      done_q    <= '0;
      id_q      <= '0;
      run_win_q <= '0;
      cont_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      sent_q    <= sent_d;
      done_q    <= done_d;
      id_q      <= id_d;
      run_win_q <= run_win_d;
      cont_q    <= cont_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    if (S_AXI_WDATA == 32'd0)               win_clamp = 8'd1;
    else if (S_AXI_WDATA > 32'(WIN_MAX))    win_clamp = 8'(WIN_MAX);
    else                                    win_clamp = S_AXI_WDATA[7:0];
  end

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      IDX_COUNTH:   rd_mux = counth_q;
      IDX_COUNTL:   rd_mux = countl_q;
      IDX_WINDOW:   rd_mux = {24'd0, window_q};
      IDX_FIRST_ID: rd_mux = first_id_q;
      IDX_STATUS:   rd_mux = {29'd0, aborted_q, state_q == S_DRAIN, state_q != S_IDLE};
      IDX_SENT_L:   rd_mux = sent_ext[31:0];
      IDX_DONE_L:   rd_mux = done_ext[31:0];
      default:      rd_mux = '0;
    endcase
  end

  // Config registers only feed the run at the next start, so writes are always accepted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      counth_q   <= '0;
      countl_q   <= 32'd32;
      window_q   <= 8'(WIN_MAX);
      first_id_q <= ID_INIT;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
      if (wr_en) begin
        bvalid_q <= 1'b1;
        bresp_q  <= RESP_OKAY;
        case (wr_idx)
          IDX_COUNTH:           counth_q   <= S_AXI_WDATA;
          IDX_COUNTL:           countl_q   <= S_AXI_WDATA;
          IDX_WINDOW:           window_q   <= win_clamp;
          IDX_FIRST_ID:         first_id_q <= S_AXI_WDATA;
          IDX_START, IDX_ABORT: ;
          default:              bresp_q    <= RESP_SLVERR;
        endcase
      end
      if (rvalid_q && S_AXI_RREADY) rvalid_q <= 1'b0;
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end
    end
  end

  assign S_AXI_AWREADY = wr_en;
  assign S_AXI_WREADY  = wr_en;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = !rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_axi_request_gen_p.sv
// Directed bench for axi_request_gen_p: register table plus multi-cycle run scenarios.
module tb_axi_request_gen_p;
  localparam int          DATA_W  = 256;
  localparam int          CNT_W   = 64;
  localparam int          WIN_MAX = 8;
  localparam logic [31:0] ID_INIT = 32'h0000_C008;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic manual_cpl = 1'b0, auto_pulse = 1'b0, button = 1'b0, tready = 1'b1;
  wire  row_complete_in = manual_cpl | auto_pulse;
  logic idle_out, tvalid, tlast;
  logic [DATA_W-1:0] tdata;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic [2:0] awprot = '0, arprot = '0;
  logic [3:0] wstrb = 4'hF;
  logic awready, wready, bvalid, arready, rvalid;
  logic bready = 1'b1, rready = 1'b1;
  logic [1:0] bresp, rresp;

  int checks = 0;
  int errors = 0;

  axi_request_gen_p #(.DATA_W(DATA_W), .CNT_W(CNT_W), .WIN_MAX(WIN_MAX), .ID_INIT(ID_INIT)) dut (
    .clk(clk), .resetn(resetn), .row_complete_in(row_complete_in), .button(button),
    .idle_out(idle_out), .AXIS_TX_TDATA(tdata), .AXIS_TX_TVALID(tvalid),
    .AXIS_TX_TLAST(tlast), .AXIS_TX_TREADY(tready),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWPROT(awprot), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARPROT(arprot), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Beat recorder: a handshake seen at a negedge completes on the following posedge.
  logic [31:0] beat_q[$];
  logic        last_q[$];
  logic        hs_pend = 1'b0, stab_en = 1'b0, auto_en = 1'b0;
  logic        prev_stall = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0;
  logic [1:0]  hs_sh = '0;

  always @(negedge clk) begin
    if (stab_en && prev_stall) begin
      chk("stall_tvalid", tvalid, 1);
      chk("stall_tdata", tdata[31:0], prev_data);
      chk("stall_tlast", tlast, prev_last);
    end
    prev_stall = resetn && tvalid && !tready;
    prev_data  = tdata[31:0];
    prev_last  = tlast;
    hs_pend    = resetn && tvalid && tready;
    if (hs_pend) begin
      beat_q.push_back(tdata[31:0]);
      last_q.push_back(tlast);
    end
  end

  always @(posedge clk) begin
    #1;
    auto_pulse = auto_en && hs_sh[1];
    hs_sh      = {hs_sh[0], hs_pend};
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic axi_write(input logic [4:0] idx, input logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    awaddr = {25'd0, idx, 2'b00};
    wdata = data;
    awvalid = 1'b1;
    wvalid = 1'b1;
    #1;
    while (!awready && n < 50) begin tick(1); n++; end
    if (!awready) begin
      checks++; errors++;
      $display("FAIL aw_handshake idx=%0d awready=0 required=1", idx);
    end
    tick(1);
    awvalid = 1'b0;
    wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin tick(1); n++; end
    resp = bresp;
    tick(1);
  endtask

  task automatic axi_read(input logic [4:0] idx, output logic [31:0] data);
    int n = 0;
    araddr = {25'd0, idx, 2'b00};
    arvalid = 1'b1;
    #1;
    while (!arready && n < 50) begin tick(1); n++; end
    tick(1);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin tick(1); n++; end
    if (!rvalid) begin
      checks++; errors++;
      $display("FAIL r_handshake idx=%0d rvalid=0 required=1", idx);
    end
    data = rdata;
    tick(1);
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] data);
    logic [1:0] r;
    axi_write(idx, data, r);
    chk("wr_resp", r, 2'b00);
  endtask

  task automatic rd_chk(input string name, input logic [4:0] idx, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(idx, d);
    chk(name, d, exp);
  endtask

  task automatic cpl();
    manual_cpl = 1'b1;
    tick(1);
    manual_cpl = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (beat_q.size() < n && k < budget) begin tick(1); k++; end
    chk("wait_beats", beat_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!idle_out && k < budget) begin tick(1); k++; end
    chk("wait_idle", idle_out, 1);
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  idx;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[19];

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int          nl;

    vecs[0]  = '{1'b0, 5'd0,  32'd0,       2'd0, 32'd0};
    vecs[1]  = '{1'b0, 5'd1,  32'd0,       2'd0, 32'd32};
    vecs[2]  = '{1'b0, 5'd4,  32'd0,       2'd0, 32'd8};
    vecs[3]  = '{1'b0, 5'd5,  32'd0,       2'd0, 32'h0000_C008};
    vecs[4]  = '{1'b0, 5'd6,  32'd0,       2'd0, 32'd0};
    vecs[5]  = '{1'b0, 5'd7,  32'd0,       2'd0, 32'd0};
    vecs[6]  = '{1'b0, 5'd8,  32'd0,       2'd0, 32'd0};
    vecs[7]  = '{1'b0, 5'd12, 32'd0,       2'd0, 32'd0};
    vecs[8]  = '{1'b1, 5'd4,  32'd0,       2'd0, 32'd0};
    vecs[9]  = '{1'b0, 5'd4,  32'd0,       2'd0, 32'd1};
    vecs[10] = '{1'b1, 5'd4,  32'd300,     2'd0, 32'd0};
    vecs[11] = '{1'b0, 5'd4,  32'd0,       2'd0, 32'd8};
    vecs[12] = '{1'b1, 5'd9,  32'h1234,    2'd2, 32'd0};
    vecs[13] = '{1'b1, 5'd5,  32'h100,     2'd0, 32'd0};
    vecs[14] = '{1'b0, 5'd5,  32'd0,       2'd0, 32'h100};
    vecs[15] = '{1'b1, 5'd4,  32'd3,       2'd0, 32'd0};
    vecs[16] = '{1'b0, 5'd4,  32'd0,       2'd0, 32'd3};
    vecs[17] = '{1'b1, 5'd4,  32'd8,       2'd0, 32'd0};
    vecs[18] = '{1'b0, 5'd2,  32'd0,       2'd0, 32'd0};

    tick(3);
    resetn = 1'b1;
    tick(1);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata[31:0], 0);
    chk("rst_idle", idle_out, 1);

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].idx, vecs[i].data, r);
        chk($sformatf("vec%0d_resp", i), r, vecs[i].resp);
      end else begin
        axi_read(vecs[i].idx, d);
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
      end
    end
    chk("table_still_idle", idle_out, 1);

    // Counted run of 5, ready high.
    beat_q.delete(); last_q.delete();
    wr(5'd1, 32'd5);
    wr(5'd2, 32'd0);
    wait_beats(5, 50);
    for (int i = 0; i < 5 && i < beat_q.size(); i++) begin
      chk($sformatf("run5_id%0d", i), beat_q[i], 32'h100 + 32'(i));
      chk($sformatf("run5_last%0d", i), last_q[i], (i == 4));
    end
    chk("run5_busy", idle_out, 0);
    repeat (4) cpl();
    chk("run5_drain_busy", idle_out, 0);
    cpl();
    chk("run5_idle", idle_out, 1);
    rd_chk("run5_sent", 5'd7, 32'd5);
    rd_chk("run5_done", 5'd8, 32'd5);

    // Window throttle: window 3, count 10.
    beat_q.delete(); last_q.delete();
    wr(5'd4, 32'd3);
    wr(5'd1, 32'd10);
    wr(5'd2, 32'd0);
    tick(20);
    chk("win_beats3", beat_q.size(), 3);
    chk("win_tvalid_low", tvalid, 0);
    for (int i = 0; i < 7; i++) begin
      cpl();
      tick(4);
      chk($sformatf("win_release%0d", i), beat_q.size(), 4 + i);
    end
    rd_chk("win_status_drain", 5'd6, 32'd3);
    repeat (3) cpl();
    chk("win_idle", idle_out, 1);
    rd_chk("win_status_done", 5'd6, 32'd0);

    // Random backpressure, count 20, automatic completions.
    beat_q.delete(); last_q.delete();
    wr(5'd4, 32'd8);
    wr(5'd1, 32'd20);
    auto_en = 1'b1;
    stab_en = 1'b1;
    wr(5'd2, 32'd0);
    for (int k = 0; k < 1000 && !(beat_q.size() == 20 && idle_out); k++) begin
      tready = 1'($urandom_range(0, 1));
      tick(1);
    end
    tready = 1'b1;
    stab_en = 1'b0;
    chk("bp_beats", beat_q.size(), 20);
    chk("bp_idle", idle_out, 1);
    for (int i = 0; i < 20 && i < beat_q.size(); i++) begin
      chk($sformatf("bp_id%0d", i), beat_q[i], 32'h100 + 32'(i));
      chk($sformatf("bp_last%0d", i), last_q[i], (i == 19));
    end
    rd_chk("bp_sent", 5'd7, 32'd20);

    // Continuous mode, abort after 50 beats.
    beat_q.delete(); last_q.delete();
    wr(5'd1, 32'd0);
    wr(5'd4, 32'd4);
    wr(5'd2, 32'd0);
    for (int k = 0; k < 1000 && beat_q.size() < 50; k++) tick(1);
    tready = 1'b0;
    chk("cont_beats50", beat_q.size(), 50);
    wr(5'd3, 32'd0);
    tready = 1'b1;
    wait_idle(200);
    tick(10);
    chk("cont_no_more", beat_q.size(), 50);
    nl = 0;
    foreach (last_q[i]) if (last_q[i]) nl++;
    chk("cont_no_tlast", nl, 0);
    rd_chk("cont_status", 5'd6, 32'd4);
    rd_chk("cont_sent", 5'd7, 32'd50);
    rd_chk("cont_done", 5'd8, 32'd50);
    auto_en = 1'b0;

    // Corner cases: stray completion, button during run, completion in IDLE.
    beat_q.delete(); last_q.delete();
    wr(5'd1, 32'd4);
    wr(5'd4, 32'd2);
    tready = 1'b0;
    button = 1'b1;
    tick(1);
    button = 1'b0;
    chk("edge_running", idle_out, 0);
    cpl();
    rd_chk("edge_done_zero", 5'd8, 32'd0);
    rd_chk("edge_status_clr", 5'd6, 32'd1);
    tready = 1'b1;
    wait_beats(2, 20);
    button = 1'b1;
    tick(1);
    button = 1'b0;
    tick(5);
    chk("edge_btn_ignored", beat_q.size(), 2);
    rd_chk("edge_sent2", 5'd7, 32'd2);
    cpl(); tick(4);
    cpl(); tick(4);
    chk("edge_beats4", beat_q.size(), 4);
    if (beat_q.size() == 4) begin
      chk("edge_id3", beat_q[3], 32'h103);
      chk("edge_last3", last_q[3], 1);
      chk("edge_last2", last_q[2], 0);
    end
    cpl();
    cpl();
    chk("edge_idle", idle_out, 1);
    cpl();
    rd_chk("edge_idle_cpl", 5'd8, 32'd4);

    // Reset in the middle of a run.
    beat_q.delete(); last_q.delete();
    wr(5'd4, 32'd3);
    wr(5'd1, 32'd10);
    wr(5'd5, 32'h55);
    wr(5'd2, 32'd0);
    wait_beats(3, 20);
    chk("mid_busy", idle_out, 0);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    chk("mid_tvalid", tvalid, 0);
    chk("mid_tlast", tlast, 0);
    chk("mid_tdata", tdata[31:0], 0);
    chk("mid_idle", idle_out, 1);
    rd_chk("mid_countl", 5'd1, 32'd32);
    rd_chk("mid_window", 5'd4, 32'(WIN_MAX));
    rd_chk("mid_first_id", 5'd5, ID_INIT);
    rd_chk("mid_sent", 5'd7, 32'd0);
    chk("mid_no_beats", beat_q.size(), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t limit=500000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
